// File: rtl/vm_pkg.sv
// vm_pkg: definitions shared by the coin acceptor and the vending-machine FSM.
//   - COIN_* : 2-bit coin codes carried on the coin bus (11 is never driven)
//   - cls_state_e : coin classifier state encoding
package vm_pkg;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;

   typedef enum logic [1:0] {
      CLS_IDLE     = 2'd0,
      CLS_DEBOUNCE = 2'd1,
      CLS_RELEASE  = 2'd2,
      CLS_JAM      = 2'd3
   } cls_state_e;

endpackage

// File: rtl/coin_fifo.sv
// coin_fifo: small synchronous FIFO holding accepted coin codes.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   push_i     write data_i this cycle (dropped when full unless pop_i also fires)
//   pop_i      remove the head entry this cycle (ignored when empty)
//   data_i     entry to write
//   data_o     current head entry (valid while empty_o is low)
//   full_o     all DEPTH entries in use
//   empty_o    no entries
//   count_o    number of stored entries, updated on the push/pop edge
//
// Handshake: push_i is a write request accepted on the clock edge when the
// FIFO is not full, or when it is full and a pop is accepted on that same
// edge; pop_i is a read request accepted on the edge when the FIFO is not
// empty. data_o is the entry that an accepted pop removes.
module coin_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             data_i,
   output logic [W-1:0]             data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i && !empty_o;
   // A full FIFO can still take a push when the head leaves on the same edge.
   assign do_push = push_i && (!full_o || do_pop);

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: vending-machine front end. Synchronises and debounces the
// two coin sensors, classifies each insertion, buffers accepted coins and
// drains them as single-cycle codes separated by idle cycles.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   sens_a      raw 5-unit sensor (asynchronous)
//   sens_b      raw 10-unit sensor (asynchronous)
//   coin        registered coin code, one cycle per coin, then >= GAP_CYCLES of 00
//   reject      registered one-cycle pulse: return the current coin
//   jam         registered level: both sensors stuck high
//   fifo_count  coins buffered and not yet emitted
//   dbg_state   classifier state, for observation only
module coin_acceptor
   import vm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int FIFO_DEPTH      = 4,
   parameter int GAP_CYCLES      = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sens_a,
   input  logic                          sens_b,
   output logic [1:0]                    coin,
   output logic                          reject,
   output logic                          jam,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output cls_state_e                    dbg_state
);

   localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int              GW   = $clog2(GAP_CYCLES + 1);
   // A count of LAST plus the current matching sample makes DEBOUNCE_CYCLES.
   localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync1_q;
   logic [1:0]    sync2_q;
   logic [1:0]    pat;

   cls_state_e    state_q;
   logic [CW-1:0] cnt_q;
   logic [1:0]    pat_q;
   logic          jam_q;
   logic          reject_q;

   logic [1:0]    coin_q;
   logic [GW-1:0] gap_q;

   logic          stable_done;
   logic          push;
   logic          jam_entry;
   logic          overflow;
   logic          pop;
   logic [1:0]    fifo_head;
   logic          fifo_full;
   logic          fifo_empty;

   // Two-flop synchroniser; pat = {sync_b, sync_a}.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {sens_b, sens_a};
         sync2_q <= sync1_q;
      end
   end
   assign pat = sync2_q;

   // The final matching sample of a debounce: decoded combinationally so the
   // push lands on the same edge the count completes.
   assign stable_done = (state_q == CLS_DEBOUNCE) && (pat == pat_q) && (cnt_q == LAST);
   assign push        = stable_done && ((pat == COIN_5) || (pat == COIN_10));
   assign jam_entry   = stable_done && (pat == 2'b11);
   assign overflow    = push && fifo_full && !pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         // Starting in RELEASE ignores any coin already sitting in the slot.
         state_q  <= CLS_RELEASE;
         cnt_q    <= '0;
         pat_q    <= '0;
         jam_q    <= 1'b0;
         reject_q <= 1'b0;
      end else begin
         reject_q <= jam_entry | overflow;
         case (state_q)
            CLS_IDLE: begin
               if (pat != 2'b00) begin
                  state_q <= CLS_DEBOUNCE;
                  cnt_q   <= CW'(1);
                  pat_q   <= pat;
               end
            end
            CLS_DEBOUNCE: begin
               if (pat == 2'b00) begin
                  state_q <= CLS_IDLE;
                  cnt_q   <= '0;
               end else if (pat != pat_q) begin
                  pat_q <= pat;
                  cnt_q <= CW'(1);
               end else if (cnt_q == LAST) begin
                  cnt_q <= '0;
                  if (pat == 2'b11) begin
                     state_q <= CLS_JAM;
                     jam_q   <= 1'b1;
                  end else begin
                     state_q <= CLS_RELEASE;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            CLS_RELEASE, CLS_JAM: begin
               // Wait for an unbroken run of empty-slot samples.
               if (pat != 2'b00) begin
                  cnt_q <= '0;
               end else if (cnt_q == LAST) begin
                  state_q <= CLS_IDLE;
                  cnt_q   <= '0;
                  jam_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= CLS_RELEASE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   coin_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (2)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (pat),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Emitter: gap_q counts the idle cycles still owed after the last code.
   assign pop = (gap_q == '0) && !fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         coin_q <= COIN_NONE;
         gap_q  <= '0;
      end else if (pop) begin
         coin_q <= fifo_head;
         gap_q  <= GW'(GAP_CYCLES);
      end else begin
         coin_q <= COIN_NONE;
         if (gap_q != '0) begin
            gap_q <= gap_q - 1'b1;
         end
      end
   end

   assign coin      = coin_q;
   assign reject    = reject_q;
   assign jam       = jam_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_coin_acceptor.sv
module tb_coin_acceptor;
   import vm_pkg::*;

   localparam int D     = 16;
   localparam int DEPTH = 4;
   localparam int G     = 200;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic       sens_a;
   logic       sens_b;
   logic [1:0] coin;
   logic       reject;
   logic       jam;
   logic [2:0] fifo_count;
   cls_state_e dbg_state;

   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   coin_acceptor #(
      .DEBOUNCE_CYCLES (D),
      .FIFO_DEPTH      (DEPTH),
      .GAP_CYCLES      (G)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sens_a     (sens_a),
      .sens_b     (sens_b),
      .coin       (coin),
      .reject     (reject),
      .jam        (jam),
      .fifo_count (fifo_count),
      .dbg_state  (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [1:0] exp_q [$];
   logic [1:0] mon_e;
   int n_cmp = 0;
   int n_bad = 0;
   int emit_cnt = 0;
   int rej_cnt = 0;
   int last_emit = -1;
   int prev_emit = -1;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic check_ge(input string name, input int act, input int req);
      n_cmp++;
      if (act < req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected at least %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every nonzero coin code is popped against the expected queue.
   always @(negedge clk) begin
      if (rst) begin
         prev_emit = -1;
      end else begin
         if (reject) rej_cnt++;
         if (coin != COIN_NONE) begin
            emit_cnt++;
            last_emit = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_coin", int'(coin), 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("coin_code", int'(coin), int'(mon_e));
            end
            if (prev_emit >= 0) check_ge("coin_gap", cyc - prev_emit - 1, G);
            prev_emit = cyc;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic at_neg(input int n);
      goto(n);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst    = 1'b1;
      sens_a = 1'b0;
      sens_b = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      // Classifier leaves RELEASE after D empty-slot samples.
      repeat (D + 4) @(posedge clk);
      #1;
   endtask

   // Drive a sensor pattern right after edge s, hold for 'hold' cycles.
   task automatic insert(input logic [1:0] code, input int s, input int hold, input bit expect_code);
      goto(s);
      sens_a = code[0];
      sens_b = code[1];
      if (expect_code) exp_q.push_back(code);
      goto(s + hold);
      sens_a = 1'b0;
      sens_b = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   int s, s2, b, e0, r0;
   logic [1:0] ov_code [8] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
   int         ov_off  [8] = '{0, 40, 80, 120, 160, 200, 240, 403};

   initial begin
      rst    = 1'b1;
      sens_a = 1'b0;
      sens_b = 1'b0;

      // Reset state
      do_reset();
      check("reset_coin", int'(coin), 0);
      check("reset_reject", int'(reject), 0);
      check("reset_jam", int'(jam), 0);
      check("reset_count", int'(fifo_count), 0);
      check("reset_state_idle", int'(dbg_state), int'(CLS_IDLE));

      // Single 5-unit coin: push 18 edges after drive, code on the next edge
      s  = cyc + 2;
      e0 = emit_cnt;
      fork
         insert(2'b01, s, 40, 1'b1);
         begin
            at_neg(s + 17);
            check("t1_count_before_push", int'(fifo_count), 0);
            at_neg(s + 18);
            check("t1_count_at_push", int'(fifo_count), 1);
            at_neg(s + 19);
            check("t1_coin_edge", int'(coin), int'(COIN_5));
            check("t1_count_after_pop", int'(fifo_count), 0);
            at_neg(s + 20);
            check("t1_coin_one_cycle", int'(coin), 0);
         end
      join
      goto(s + 80);
      check("t1_emit_cycle", last_emit, s + 19);
      check("t1_emit_count", emit_cnt - e0, 1);

      // Short sens_b glitches never reach the debounce count
      do_reset();
      e0 = emit_cnt;
      r0 = rej_cnt;
      for (int i = 0; i < 4; i++) begin
         s = cyc + 1;
         insert(2'b10, s, 5, 1'b0);
         goto(s + 15);
      end
      goto(cyc + 20);
      check("t2_no_coin", emit_cnt - e0, 0);
      check("t2_no_reject", rej_cnt - r0, 0);
      check("t2_state_idle", int'(dbg_state), int'(CLS_IDLE));

      // Jam: both sensors high
      do_reset();
      s  = cyc + 2;
      e0 = emit_cnt;
      r0 = rej_cnt;
      fork
         insert(2'b11, s, 30, 1'b0);
         begin
            at_neg(s + 17);
            check("t3_jam_before", int'(jam), 0);
            at_neg(s + 18);
            check("t3_jam_set", int'(jam), 1);
            check("t3_reject_pulse", int'(reject), 1);
            at_neg(s + 19);
            check("t3_reject_one_cycle", int'(reject), 0);
            at_neg(s + 25);
            check("t3_state_jam", int'(dbg_state), int'(CLS_JAM));
            at_neg(s + 47);
            check("t3_jam_held", int'(jam), 1);
            at_neg(s + 48);
            check("t3_jam_cleared", int'(jam), 0);
            check("t3_state_idle", int'(dbg_state), int'(CLS_IDLE));
         end
      join
      check("t3_reject_count", rej_cnt - r0, 1);
      check("t3_no_coin", emit_cnt - e0, 0);
      check("t3_count", int'(fifo_count), 0);

      // Overflow and same-edge push/pop while full
      do_reset();
      b  = cyc + 2;
      e0 = emit_cnt;
      r0 = rej_cnt;
      fork
         for (int i = 0; i < 8; i++) begin
            insert(ov_code[i], b + ov_off[i], 20, (i != 5));
         end
         begin
            at_neg(b + 178);
            check("t4_full", int'(fifo_count), 4);
            check("t4_no_reject_fill", rej_cnt - r0, 0);
            at_neg(b + 218);
            check("t4_overflow_reject", int'(reject), 1);
            check("t4_count_kept", int'(fifo_count), 4);
            at_neg(b + 219);
            check("t4_reject_one_cycle", int'(reject), 0);
            at_neg(b + 220);
            check("t4_count_after_pop", int'(fifo_count), 3);
            at_neg(b + 258);
            check("t4_refill", int'(fifo_count), 4);
            at_neg(b + 421);
            check("t5_no_reject_pushpop", int'(reject), 0);
            check("t5_count_unchanged", int'(fifo_count), 4);
            check("t5_coin_popped", int'(coin), int'(COIN_5));
         end
      join
      goto(b + 1300);
      check("t4_drain_count", int'(fifo_count), 0);
      check("t4_reject_total", rej_cnt - r0, 1);
      check("t4_emit_total", emit_cnt - e0, 7);

      // Reset while a coin is being debounced
      do_reset();
      s = cyc + 2;
      insert(2'b01, s, 20, 1'b1);
      insert(2'b10, s + 40, 20, 1'b0);   // buffered behind the gap, lost at reset
      goto(s + 80);
      sens_a = 1'b1;
      at_neg(s + 85);
      check("t6_buffered", int'(fifo_count), 1);
      at_neg(s + 89);
      check("t6_mid_debounce", int'(dbg_state), int'(CLS_DEBOUNCE));
      goto(s + 90);
      rst = 1'b1;
      at_neg(s + 91);
      check("t6_rst_coin", int'(coin), 0);
      check("t6_rst_reject", int'(reject), 0);
      check("t6_rst_jam", int'(jam), 0);
      check("t6_rst_count", int'(fifo_count), 0);
      check("t6_rst_state", int'(dbg_state), int'(CLS_RELEASE));
      goto(s + 92);
      rst = 1'b0;
      e0  = emit_cnt;
      at_neg(s + 140);
      check("t6_held_release", int'(dbg_state), int'(CLS_RELEASE));
      goto(s + 150);
      sens_a = 1'b0;
      at_neg(s + 175);
      check("t6_idle_again", int'(dbg_state), int'(CLS_IDLE));
      check("t6_no_code_after_rst", emit_cnt - e0, 0);
      s2 = s + 180;
      insert(2'b01, s2, 20, 1'b1);
      goto(s2 + 30);
      check("t6_reinsert_emit", last_emit, s2 + 19);
      check("t6_reinsert_count", emit_cnt - e0, 1);

      goto(cyc + 10);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
